// File: rtl/ascii_num_entry.sv
// Builds a decimal operand from ASCII digit strobes and emits it on Enter.
// Entries that are too long or larger than MAX_VAL produce an error pulse instead of a value.
module ascii_num_entry #(
  parameter int MAX_DIGITS = 2,
  parameter int W          = 7,
  parameter int MAX_VAL    = 24
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [7:0]                          ascii_code,
  input  logic                                ascii_valid,
  input  logic                                clr,
  output logic [W-1:0]                        value,
  output logic                                done,
  output logic                                err,
  output logic [$clog2(MAX_DIGITS+1)-1:0]     digit_cnt,
  output logic                                busy
);

  localparam int CW = $clog2(MAX_DIGITS+1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OVF} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  value_q, value_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic          is_digit;
  logic          is_enter;
  logic [3:0]    digit;

  assign is_digit = (ascii_code >= 8'h30) && (ascii_code <= 8'h39);
  assign is_enter = (ascii_code == 8'h0D);
  // Low nibble of 0x30..0x39 is the digit itself.
  assign digit    = ascii_code[3:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (ascii_valid && is_digit) begin
      case (state_q)
        S_IDLE: begin
          acc_d   = W'(digit);
          cnt_d   = CW'(1);
          state_d = S_ACC;
        end
        S_ACC: begin
          if (cnt_q < CW'(MAX_DIGITS)) begin
            acc_d = acc_q * W'(10) + W'(digit);
            cnt_d = cnt_q + CW'(1);
          end else begin
            state_d = S_OVF;
          end
        end
        default: state_d = S_OVF;
      endcase
    end else if (ascii_valid && is_enter) begin
      case (state_q)
        S_ACC: begin
          if (acc_q <= W'(MAX_VAL)) begin
            value_d = acc_q;
            done_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        S_OVF: begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: ;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign value     = value_q;
  assign done      = done_q;
  assign err       = err_q;
  assign digit_cnt = cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ascii_num_entry.sv
// Directed bench for ascii_num_entry: digit accumulation, Enter handling,
// range/length rejection, ignored bytes, clr priority and asynchronous reset.
module tb_ascii_num_entry;

  logic       clk;
  logic       reset;
  logic [7:0] ascii_code;
  logic       ascii_valid;
  logic       clr;
  logic [6:0] value;
  logic       done;
  logic       err;
  logic [1:0] digit_cnt;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  ascii_num_entry #(.MAX_DIGITS(2), .W(7), .MAX_VAL(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .ascii_code (ascii_code),
    .ascii_valid(ascii_valid),
    .clr        (clr),
    .value      (value),
    .done       (done),
    .err        (err),
    .digit_cnt  (digit_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Strobe one byte; returns 1 time unit after the sampling edge.
  task automatic press(input logic [7:0] c, input logic with_clr = 1'b0);
    @(negedge clk);
    ascii_code  = c;
    ascii_valid = 1'b1;
    clr         = with_clr;
    @(posedge clk);
    #1;
    ascii_valid = 1'b0;
    clr         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int v, input int d, input int e,
                         input int cnt, input int b);
    chk({tag, ".value"}, int'(value), v);
    chk({tag, ".done"}, int'(done), d);
    chk({tag, ".err"}, int'(err), e);
    chk({tag, ".cnt"}, int'(digit_cnt), cnt);
    chk({tag, ".busy"}, int'(busy), b);
  endtask

  initial begin
    reset       = 1'b1;
    ascii_code  = 8'h00;
    ascii_valid = 1'b0;
    clr         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // "24" Enter: accepted at the limit
    press(8'h32);  chk_out("d2", 0, 0, 0, 1, 1);
    press(8'h34);  chk_out("d24", 0, 0, 0, 2, 1);
    press(8'h0D);  chk_out("ent24", 24, 1, 0, 0, 0);
    tick();        chk_out("ent24_after", 24, 0, 0, 0, 0);

    // "25" Enter: out of range
    press(8'h32);
    press(8'h35);  chk_out("d25", 24, 0, 0, 2, 1);
    press(8'h0D);  chk_out("ent25", 24, 0, 1, 0, 0);
    tick();        chk_out("ent25_after", 24, 0, 0, 0, 0);

    // "123" Enter: too many digits
    press(8'h31);
    press(8'h32);
    press(8'h33);  chk_out("ovf", 24, 0, 0, 2, 1);
    press(8'h34);  chk_out("ovf_more", 24, 0, 0, 2, 1);
    press(8'h0D);  chk_out("ent_ovf", 24, 0, 1, 0, 0);

    // "7", '*', 'A', Enter: junk bytes ignored
    press(8'h37);
    press(8'h2A);  chk_out("star", 24, 0, 0, 1, 1);
    press(8'h41);  chk_out("A", 24, 0, 0, 1, 1);
    @(negedge clk);
    ascii_code = 8'h35;  // digit present but no strobe
    tick();        chk_out("novalid", 24, 0, 0, 1, 1);
    press(8'h0D);  chk_out("ent7", 7, 1, 0, 0, 0);
    tick();
    press(8'h0D);  chk_out("ent_idle", 7, 0, 0, 0, 0);

    // "9", then clr together with '1'; then "3" Enter
    press(8'h39);  chk_out("d9", 7, 0, 0, 1, 1);
    press(8'h31, 1'b1); chk_out("clr", 7, 0, 0, 0, 0);
    press(8'h33);
    press(8'h0D);  chk_out("ent3", 3, 1, 0, 0, 0);

    // Digit right after Enter starts a new entry
    press(8'h31);  chk_out("after_ent", 3, 0, 0, 1, 1);
    press(8'h0D);  chk_out("ent1", 1, 1, 0, 0, 0);

    // Leading zero counts as a digit
    press(8'h30);
    press(8'h35);  chk_out("d05", 1, 0, 0, 2, 1);
    press(8'h36);  chk_out("d056", 1, 0, 0, 2, 1);
    press(8'h0D);  chk_out("ent056", 1, 0, 1, 0, 0);
    press(8'h30);
    press(8'h35);
    press(8'h0D);  chk_out("ent05", 5, 1, 0, 0, 0);

    // Asynchronous reset mid-entry
    press(8'h31);  chk_out("pre_rst", 5, 0, 0, 1, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    press(8'h30);  chk_out("d0", 0, 0, 0, 1, 1);
    press(8'h38);  chk_out("d08", 0, 0, 0, 2, 1);
    press(8'h0D);  chk_out("ent08", 8, 1, 0, 0, 0);
    tick();        chk_out("ent08_after", 8, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
